// File: rtl/encoder4x2_rr_pkg.sv
// Shared sizing, types and helpers for the registered 4-to-2 round-robin encoder.
// N_REQ/IDX_W/RST_PTR are the common encoder definitions used by every file in this slice.
package encoder4x2_rr_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] req_t;

  // Pointer reset value: the last-granted index is taken as 3 so the first search begins at 0.
  localparam idx_t RST_PTR = 2'b11;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  function automatic req_t onehot(input idx_t idx);
    req_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/encoder4x2_rr_pick4.sv
// Combinational picker: round-robin search after ptr, or fixed priority with index 3 highest.
// any flags that at least one request is present; sel is meaningless when any is low.
module rr_pick4
  import encoder4x2_rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_en,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  idx_t cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_hit;
  idx_t rr_sel;
  idx_t fp_sel;

  // Candidate gi is the index gi+1 steps after the last grant; 2-bit arithmetic gives the wrap.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = ptr + idx_t'(gi + 1);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    rr_sel = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        rr_sel = cand_idx[k];
      end
    end
  end

  always_comb begin
    fp_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        fp_sel = idx_t'(i);
      end
    end
  end

  assign any = |req;
  assign sel = (arb_mode_t'(rr_en) == ARB_RR) ? rr_sel : fp_sel;

endmodule

// File: rtl/encoder4x2_rr.sv
// Registered 4-to-2 encoder: latches request pulses as pending and hands out one index per
// valid/ready transfer. All outputs come straight from registers.
module encoder4x2_rr
  import encoder4x2_rr_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] din,
  input  logic             ready,
  output logic [IDX_W-1:0] dout,
  output logic             valid,
  output logic [N_REQ-1:0] pend
);

  req_t pend_reg, pend_next;
  idx_t dout_reg, dout_next;
  idx_t ptr_reg, ptr_next;
  logic valid_reg, valid_next;

  idx_t sel;
  logic any;
  logic load;
  req_t clr;
  req_t set_mask;

  rr_pick4 u_pick (
    .req   (pend_reg),
    .ptr   (ptr_reg),
    .rr_en (RR_EN),
    .sel   (sel),
    .any   (any)
  );

  always_comb begin
    load       = 1'b0;
    clr        = '0;
    set_mask   = '0;
    pend_next  = pend_reg;
    dout_next  = dout_reg;
    ptr_next   = ptr_reg;
    valid_next = valid_reg;

    // The slot may refill whenever it is empty or being emptied this cycle.
    load = (!valid_reg || ready) && any;

    if (load) begin
      clr        = onehot(sel);
      dout_next  = sel;
      ptr_next   = sel;
      valid_next = 1'b1;
    end else if (valid_reg && ready) begin
      valid_next = 1'b0;
    end

    set_mask = en ? din : '0;
    // Clear is applied before set so a fresh request on the granted bit stays pending.
    pend_next = (pend_reg & ~clr) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg  <= '0;
      dout_reg  <= '0;
      ptr_reg   <= RST_PTR;
      valid_reg <= 1'b0;
    end else begin
      pend_reg  <= pend_next;
      dout_reg  <= dout_next;
      ptr_reg   <= ptr_next;
      valid_reg <= valid_next;
    end
  end

  assign dout  = dout_reg;
  assign valid = valid_reg;
  assign pend  = pend_reg;

endmodule
